// File: rtl/mem_wb_stage_buf.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_buf
//
// Elastic MEM/WB pipeline stage. It holds the data-memory read result, the ALU
// result, the destination register and the writeback control bits. Storage is
// a main register plus a one-entry skid buffer, so the upstream ready signal
// comes straight from a flop and never depends on out_ready in the same cycle.
// Read data and ALU result are stored in the same entry, so they stay aligned
// under backpressure. The control bits are gated by the entry-valid flag, so a
// bubble can never write the register file.
//
// Optional feature (macro MEM_WB_FWD_EN):
//   When defined, fwd_valid/fwd_reg/fwd_data expose the main entry's writeback
//   value for EX-stage bypass. When undefined, all three are tied to zero.
//
// Parameters:
//   DATA_W        width of read data and ALU result
//   REG_W         width of destination register index
//   CTR_W         width of writeback control field
//   MEMTOREG_BIT  ctrl bit selecting read data (1) or ALU result (0)
//   REGWRITE_BIT  ctrl bit enabling the register-file write
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 squash every held entry and any input this cycle
//   in_valid / in_ready   upstream handshake (in_ready = !skid_valid)
//   ctrl_in, read_data_in, alu_result_in, write_reg_in   incoming entry
//   out_valid / out_ready downstream handshake on the main entry
//   ctrl_out              main ctrl gated by out_valid
//   read_data, alu_result, write_reg   main payload (shown even when invalid)
//   fwd_valid, fwd_reg, fwd_data       forwarding view of the main entry
// ---------------------------------------------------------------------------
module mem_wb_stage_buf #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int CTR_W        = 2,
    parameter int MEMTOREG_BIT = 0,
    parameter int REGWRITE_BIT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTR_W-1:0]  ctrl_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTR_W-1:0]  ctrl_out,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [REG_W-1:0]  write_reg,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);

    logic              main_valid;
    logic [CTR_W-1:0]  main_ctrl;
    logic [DATA_W-1:0] main_rd;
    logic [DATA_W-1:0] main_alu;
    logic [REG_W-1:0]  main_reg;

    logic              skid_valid;
    logic [CTR_W-1:0]  skid_ctrl;
    logic [DATA_W-1:0] skid_rd;
    logic [DATA_W-1:0] skid_alu;
    logic [REG_W-1:0]  skid_reg;

    logic in_xfer;
    logic out_xfer;

    // The skid register is the only thing that can refuse an input, so ready
    // is purely a function of stored state.
    assign in_ready = !skid_valid;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    // Entry occupancy: EMPTY (no main), ONE (main only), FULL (main + skid).
    // The skid entry is always younger than main, so it only ever moves into
    // main when main leaves, which preserves order. Flush drops both valid
    // flags but leaves the payload registers untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_rd    <= '0;
            main_alu   <= '0;
            main_reg   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_rd    <= '0;
            skid_alu   <= '0;
            skid_reg   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (in_xfer) begin
                main_valid <= 1'b1;
                main_ctrl  <= ctrl_in;
                main_rd    <= read_data_in;
                main_alu   <= alu_result_in;
                main_reg   <= write_reg_in;
            end
        end else if (!skid_valid) begin
            if (out_xfer && in_xfer) begin
                main_ctrl <= ctrl_in;
                main_rd   <= read_data_in;
                main_alu  <= alu_result_in;
                main_reg  <= write_reg_in;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end else if (in_xfer) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= ctrl_in;
                skid_rd    <= read_data_in;
                skid_alu   <= alu_result_in;
                skid_reg   <= write_reg_in;
            end
        end else if (out_xfer) begin
            main_ctrl  <= skid_ctrl;
            main_rd    <= skid_rd;
            main_alu   <= skid_alu;
            main_reg   <= skid_reg;
            skid_valid <= 1'b0;
        end
    end

    assign out_valid  = main_valid;
    assign ctrl_out   = main_ctrl & {CTR_W{main_valid}};
    assign read_data  = main_rd;
    assign alu_result = main_alu;
    assign write_reg  = main_reg;

`ifdef MEM_WB_FWD_EN
    // Register 0 is hard-wired to zero, so a write to it never forwards.
    assign fwd_valid = main_valid & main_ctrl[REGWRITE_BIT] & (main_reg != '0);
    assign fwd_reg   = main_reg;
    assign fwd_data  = main_ctrl[MEMTOREG_BIT] ? main_rd : main_alu;
`else
    // Forwarding disabled. The control-bit indices are still referenced so
    // both builds use the same parameter set; the AND with zero folds away.
    assign fwd_valid = main_ctrl[REGWRITE_BIT] & main_ctrl[MEMTOREG_BIT] & 1'b0;
    assign fwd_reg   = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage_buf
//
// Scoreboard bench for mem_wb_stage_buf. The stage is modelled as an ordered
// queue with capacity two: accepted entries are appended by the stimulus side,
// and a separate monitor compares the DUT's outputs against the queue head
// every cycle and removes the head when the consumer takes it. Flush and reset
// empty the queue.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage_buf;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTR_W  = 2;

    typedef struct packed {
        logic [CTR_W-1:0]  ctrl;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  wreg;
    } entry_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTR_W-1:0]  ctrl_in = '0;
    logic [DATA_W-1:0] read_data_in = '0;
    logic [DATA_W-1:0] alu_result_in = '0;
    logic [REG_W-1:0]  write_reg_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTR_W-1:0]  ctrl_out;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_reg;
    logic [DATA_W-1:0] fwd_data;

    entry_t exp_q[$];
    logic   model_in_ready = 1'b1;
    int     vectors = 0;
    int     miscompares = 0;

    mem_wb_stage_buf #(
        .DATA_W(DATA_W), .REG_W(REG_W), .CTR_W(CTR_W),
        .MEMTOREG_BIT(0), .REGWRITE_BIT(1)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .read_data_in(read_data_in),
        .alu_result_in(alu_result_in), .write_reg_in(write_reg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .read_data(read_data),
        .alu_result(alu_result), .write_reg(write_reg),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus: drive just after the rising edge, then
    // after the falling edge (where the monitor has already looked) record
    // what the model says the coming edge does to the queue.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [CTR_W-1:0] c, input logic [DATA_W-1:0] rdv,
                                 input logic [DATA_W-1:0] aluv, input logic [REG_W-1:0] rg,
                                 input logic ordy);
        entry_t e;
        @(posedge clock);
        #1;
        reset = rst; flush = fl; in_valid = iv; ctrl_in = c;
        read_data_in = rdv; alu_result_in = aluv; write_reg_in = rg; out_ready = ordy;
        @(negedge clock);
        #1;
        if (rst || fl) begin
            exp_q.delete();
        end else if (iv && model_in_ready) begin
            e.ctrl = c; e.rd = rdv; e.alu = aluv; e.wreg = rg;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, ordy);
    endtask

    task automatic push(input logic [CTR_W-1:0] c, input logic [DATA_W-1:0] rdv,
                        input logic [DATA_W-1:0] aluv, input logic [REG_W-1:0] rg,
                        input logic ordy);
        applyStimulus(1'b0, 1'b0, 1'b1, c, rdv, aluv, rg, ordy);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        checkOutput({tag, "_ctrl_out"}, {30'b0, ctrl_out}, 32'd0);
        checkOutput({tag, "_alu_result"}, alu_result, 32'd0);
        checkOutput({tag, "_read_data"}, read_data, 32'd0);
        checkOutput({tag, "_write_reg"}, {27'b0, write_reg}, 32'd0);
        checkOutput({tag, "_fwd_valid"}, {31'b0, fwd_valid}, 32'd0);
    endtask

    // Monitor: the queue holds exactly what the stage holds at this point.
    always @(negedge clock) begin
        entry_t h;
        logic   fv;
        model_in_ready = (exp_q.size() < 2);
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, model_in_ready});
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            checkOutput("ctrl_out", {30'b0, ctrl_out}, {30'b0, h.ctrl});
            checkOutput("alu_result", alu_result, h.alu);
            checkOutput("read_data", read_data, h.rd);
            checkOutput("write_reg", {27'b0, write_reg}, {27'b0, h.wreg});
`ifdef MEM_WB_FWD_EN
            fv = h.ctrl[1] && (h.wreg != 0);
            checkOutput("fwd_valid", {31'b0, fwd_valid}, {31'b0, fv});
            checkOutput("fwd_reg", {27'b0, fwd_reg}, {27'b0, h.wreg});
            checkOutput("fwd_data", fwd_data, h.ctrl[0] ? h.rd : h.alu);
`else
            fv = 1'b0;
            checkOutput("fwd_valid", {31'b0, fwd_valid}, {31'b0, fv});
            checkOutput("fwd_reg", {27'b0, fwd_reg}, 32'd0);
            checkOutput("fwd_data", fwd_data, 32'd0);
`endif
            if (out_ready) exp_q.pop_front();
        end else begin
            checkOutput("ctrl_out_idle", {30'b0, ctrl_out}, 32'd0);
            checkOutput("fwd_valid_idle", {31'b0, fwd_valid}, 32'd0);
`ifndef MEM_WB_FWD_EN
            checkOutput("fwd_reg_idle", {27'b0, fwd_reg}, 32'd0);
            checkOutput("fwd_data_idle", fwd_data, 32'd0);
`endif
        end
    end

    initial begin
        // Reset from power-up.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        idle(1'b0);
        checkResetState("por");

        // Single entry through an empty stage with the consumer ready.
        push(2'b10, 32'h0, 32'h0000_1234, 5'd7, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A then B fill the stage, then drain in order.
        push(2'b10, 32'h0, 32'h11, 5'd1, 1'b0);
        push(2'b10, 32'h0, 32'h22, 5'd2, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with an input offered in the same cycle.
        push(2'b11, 32'h5, 32'h44, 5'd3, 1'b0);
        push(2'b11, 32'h6, 32'h55, 5'd4, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'h33, 5'd5, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Eight back-to-back entries with the consumer always ready.
        for (int i = 0; i < 8; i++)
            push(2'(i), 32'(i * 3), 32'(32'h100 + i), 5'(i + 1), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Forwarding view: load select with non-zero and zero destination.
        push(2'b11, 32'h0000_DEAD, 32'h0000_BEEF, 5'd9, 1'b0);
        idle(1'b1);
        push(2'b11, 32'h0000_DEAD, 32'h0000_BEEF, 5'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset in the middle of traffic with the stage full.
        push(2'b10, 32'h7, 32'h77, 5'd6, 1'b0);
        push(2'b10, 32'h8, 32'h88, 5'd8, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 32'h9, 32'h99, 5'd9, 1'b0);
        idle(1'b0);
        checkResetState("mid");

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) < 7),
                          CTR_W'($urandom_range(0, 3)), $urandom, $urandom,
                          REG_W'($urandom_range(0, 31)),
                          ($urandom_range(0, 9) < 6));
        end

        // Drain and confirm the stage ends empty.
        for (int i = 0; i < 4; i++) idle(1'b1);
        checkOutput("drained_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("drained_in_ready", {31'b0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_buf.md
Name: mem_wb_stage_buf

Overview:
- Parametrised MEM/WB pipeline stage between data memory / ALU result and register-file writeback.
- Replaces the fixed-width MEM/WB register with a valid/ready elastic stage: main register plus one-entry skid buffer, stall and flush.
- Read data is registered alongside the ALU result, so both stay aligned under backpressure.
- Writeback control bits are gated so a bubble can never write the register file.

Parameters:
DATA_W, 32, width of read data and ALU result
REG_W, 5, width of destination register index
CTR_W, 2, width of writeback control field
MEMTOREG_BIT, 0, index in ctrl of the select bit (1 = write read data, 0 = write ALU result)
REGWRITE_BIT, 1, index in ctrl of the register-write enable

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept; equals !skid_valid
ctrl_in  in  CTR_W  writeback control bits
read_data_in  in  DATA_W  data-memory read result
alu_result_in  in  DATA_W  ALU result
write_reg_in  in  REG_W  destination register
out_valid  out  1  main entry valid
out_ready  in  1  writeback consumes main entry
ctrl_out  out  CTR_W  control bits of main entry; all zero when !out_valid
read_data  out  DATA_W  registered read data
alu_result  out  DATA_W  registered ALU result
write_reg  out  REG_W  registered destination
fwd_valid  out  1  forwarding entry valid (optional feature)
fwd_reg  out  REG_W  forwarding destination (optional feature)
fwd_data  out  DATA_W  forwarding value (optional feature)

Behaviour:
- Reset (synchronous, active-high, highest priority): main_valid=0, skid_valid=0, all payload registers=0. Every output is 0 except in_ready=1.
- Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Latency: one cycle from input accept to out_valid when the stage is empty.
- Entry states and next-state rules:
  - EMPTY (main=0, skid=0): an accepted input loads main.
  - ONE (main=1, skid=0):
    - Output transfer with input: main <= input.
    - Output transfer without input: go to EMPTY.
    - No output transfer, with input: skid <= input; go to FULL.
  - FULL (main=1, skid=1): in_ready=0. On output transfer: main <= skid, skid_valid=0.
- Order is preserved: skid contents always leave after main.
- flush (below reset, above all else): main_valid=0, skid_valid=0.
  - Any input presented that cycle is discarded.
  - Payload registers hold their values, but ctrl_out reads 0.
- ctrl_out = main ctrl & {CTR_W{main_valid}}.
- read_data, alu_result and write_reg show the main payload even when invalid; consumers qualify them with out_valid / ctrl_out.
- out_ready=1 every cycle gives the throughput and latency of a plain register; the skid buffer stays unused.
- in_ready is a registered-state function only; there is no combinational path from out_ready to in_ready.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- Defined:
  - fwd_valid = main_valid & ctrl[REGWRITE_BIT] & (write_reg != 0).
  - fwd_reg = main write_reg.
  - fwd_data = ctrl[MEMTOREG_BIT] ? main read_data : main alu_result.
  - All three are combinational from the main registers, for EX-stage bypass.
- Undefined: fwd_valid, fwd_reg and fwd_data are tied to 0; no mux logic is built.

Test Plan:
- Reset mid-stream with FULL state -> next cycle out_valid=0, in_ready=1, ctrl_out=0, alu_result=0, read_data=0.
- Empty stage, out_ready=1, input {ctrl=2'b10, alu=32'h0000_1234, reg=5'd7} -> one cycle later out_valid=1, alu_result=32'h1234, write_reg=7, ctrl_out=2'b10.
- out_ready=0, inputs A (alu=0x11) then B (alu=0x22) -> in_ready=0 after B. Then out_ready=1 -> outputs A then B on consecutive cycles, then in_ready=1.
- FULL state, flush=1 with in_valid=1 (alu=0x33) -> next cycle out_valid=0, ctrl_out=0, in_ready=1; entry 0x33 never appears.
- Back-to-back 8 inputs with out_ready=1 -> 8 outputs in order, one per cycle, in_ready constantly 1.
- MEM_WB_FWD_EN defined:
  - Main entry ctrl=2'b11, read_data=0xDEAD, reg=9 -> fwd_valid=1, fwd_reg=9, fwd_data=0xDEAD.
  - reg=0 -> fwd_valid=0.
  - Macro undefined -> fwd_* all 0.
